// File: rtl/bsg_unconcentrate_stream.sv
// bsg_unconcentrate_stream
// Sequential scatter engine: packed items arrive in narrow beats and are placed,
// in order, into the set-bit slots of a runtime-loaded pattern mask. One wide
// word is emitted on a valid/yumi port once every pattern slot has been filled.
// Optional build macro: BSG_UNCONCENTRATE_STREAM_OVERLAP_EN lets a new word start
// in the same cycle the finished word is consumed, removing the per-word bubble.

module bsg_unconcentrate_stream #(
  parameter int els_p    = 32,
  parameter int width_p  = 1,
  parameter int in_els_p = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          cfg_v_i,
  input  logic [els_p-1:0]              cfg_pattern_i,
  output logic                          cfg_ready_o,
  input  logic                          v_i,
  input  logic [in_els_p*width_p-1:0]   data_i,
  output logic                          ready_o,
  output logic                          v_o,
  output logic [els_p*width_p-1:0]      data_o,
  input  logic                          yumi_i
);

  localparam int rank_w_lp = $clog2(els_p + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_e;

  // Number of set bits in a pattern; this is the item count of one word.
  function automatic logic [rank_w_lp-1:0] popcount(input logic [els_p-1:0] vec);
    logic [rank_w_lp-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < els_p; i++) begin
      cnt = cnt + rank_w_lp'(vec[i]);
    end
    return cnt;
  endfunction

  // Places item k of a beat into the set slot whose ordinal equals base+k.
  // Items whose ordinal would exceed the last set slot find no slot and vanish.
  function automatic logic [els_p*width_p-1:0] scatter(
    input logic [els_p-1:0]            pat,
    input logic [rank_w_lp-1:0]        base,
    input logic [in_els_p*width_p-1:0] items
  );
    logic [rank_w_lp:0]         ord;
    logic [els_p*width_p-1:0]   word;
    word = '0;
    ord  = '0;
    for (int s = 0; s < els_p; s++) begin
      if (pat[s]) begin
        for (int k = 0; k < in_els_p; k++) begin
          if (ord == ({1'b0, base} + (rank_w_lp+1)'(k))) begin
            word[s*width_p +: width_p] = items[k*width_p +: width_p];
          end
        end
        ord = ord + (rank_w_lp+1)'(1);
      end
    end
    return word;
  endfunction

  // Rank after one beat, saturated at the word's item count.
  function automatic logic [rank_w_lp-1:0] advance(
    input logic [rank_w_lp-1:0] base,
    input logic [rank_w_lp-1:0] n
  );
    logic [rank_w_lp:0] sum;
    sum = {1'b0, base} + (rank_w_lp+1)'(in_els_p);
    if (sum >= {1'b0, n}) begin
      return n;
    end else begin
      return sum[rank_w_lp-1:0];
    end
  endfunction

  state_e                     state_r, state_n;
  logic [els_p-1:0]           pat_r, pat_n;
  logic [rank_w_lp-1:0]       n_r, n_n;
  logic [rank_w_lp-1:0]       rank_r, rank_n;
  logic [els_p*width_p-1:0]   data_r, data_n;
  logic                       v_r, v_n;
  logic                       ready_s;
  logic                       cfg_ready_s;

  // State, pattern, rank and output word registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
      pat_r   <= '0;
      n_r     <= '0;
      rank_r  <= '0;
      data_r  <= '0;
      v_r     <= 1'b0;
    end else begin
      state_r <= state_n;
      pat_r   <= pat_n;
      n_r     <= n_n;
      rank_r  <= rank_n;
      data_r  <= data_n;
      v_r     <= v_n;
    end
  end

  // Next-state, handshake and scatter logic.
  always_comb begin
    state_n     = state_r;
    pat_n       = pat_r;
    n_n         = n_r;
    rank_n      = rank_r;
    data_n      = data_r;
    ready_s     = 1'b0;
    cfg_ready_s = 1'b0;

    case (state_r)
      IDLE: begin
        cfg_ready_s = 1'b1;
        if (cfg_v_i) begin
          pat_n   = cfg_pattern_i;
          n_n     = popcount(cfg_pattern_i);
          rank_n  = '0;
          data_n  = '0;
          state_n = FILL;
        end else begin
          state_n = IDLE;
        end
      end

      FILL: begin
        // A pattern may only be swapped before the first item of a word lands,
        // and a pending load blocks beats so the load always wins.
        cfg_ready_s = (rank_r == '0);
        ready_s     = ((rank_r == '0) ? !cfg_v_i : 1'b1) & (n_r != '0);
        if (cfg_v_i && cfg_ready_s) begin
          pat_n   = cfg_pattern_i;
          n_n     = popcount(cfg_pattern_i);
          rank_n  = '0;
          data_n  = '0;
          state_n = FILL;
        end else if (n_r == '0) begin
          data_n  = '0;
          state_n = FULL;
        end else if (v_i && ready_s) begin
          data_n = data_r | scatter(pat_r, rank_r, data_i);
          rank_n = advance(rank_r, n_r);
          if (rank_n == n_r) begin
            state_n = FULL;
          end else begin
            state_n = FILL;
          end
        end else begin
          state_n = FILL;
        end
      end

      FULL: begin
`ifdef BSG_UNCONCENTRATE_STREAM_OVERLAP_EN
        ready_s = yumi_i & (n_r != '0);
`else
        ready_s = 1'b0;
`endif
        cfg_ready_s = 1'b0;
        if (yumi_i) begin
          data_n  = '0;
          rank_n  = '0;
          state_n = FILL;
`ifdef BSG_UNCONCENTRATE_STREAM_OVERLAP_EN
          // The beat arriving with yumi starts the next word from rank 0.
          if (v_i && ready_s) begin
            data_n = scatter(pat_r, '0, data_i);
            rank_n = advance('0, n_r);
            if (rank_n == n_r) begin
              state_n = FULL;
            end else begin
              state_n = FILL;
            end
          end else begin
            state_n = FILL;
          end
`endif
        end else begin
          state_n = FULL;
        end
      end

      default: begin
        state_n = IDLE;
        pat_n   = '0;
        n_n     = '0;
        rank_n  = '0;
        data_n  = '0;
      end
    endcase

    v_n = (state_n == FULL);
  end

  assign ready_o     = ready_s;
  assign cfg_ready_o = cfg_ready_s;
  assign v_o         = v_r;
  assign data_o      = data_r;

`ifndef SYNTHESIS
  bsg_unconcentrate_stream_chk chk (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_o       (v_r),
    .yumi_i    (yumi_i)
  );
`endif

endmodule

// Protocol checker: the consumer may only take a word that is being offered.
module bsg_unconcentrate_stream_chk (
  input logic clk_i,
  input logic reset_n_i,
  input logic v_o,
  input logic yumi_i
);
  yumi_only_with_v: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);
endmodule
